// File: rtl/sr_dmem.sv
// rtl/sr_dmem.sv - schoolRISCV data memory with CYCLE/GPIO MMIO; optional SR_DMEM_MISALIGN_CHECK_EN
module sr_dmem #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmAddr,
    input  logic [31:0] dmDataW,
    input  logic        dmWe,
    input  logic        op_byte,
    input  logic        op_half,
    input  logic        op_word,
    input  logic        dmSign,
    output logic [31:0] dmDataR,
    output logic [31:0] gpioOut
`ifdef SR_DMEM_MISALIGN_CHECK_EN
    ,
    output logic        misalignErr
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   cycle_q;
    logic [31:0]   gpio_q;
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          is_mmio;
    logic          store_en;
    logic [AW-1:0] idx;
    logic [1:0]    reg_sel;
    logic [1:0]    off;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic          unused;

    // op_word carries no information beyond "neither byte nor half"
    assign is_byte = op_byte;
    assign is_half = !op_byte && op_half;
    assign is_word = !op_byte && !op_half;
    assign unused  = ^{op_word, dmAddr[27:4]};

    assign is_mmio = (dmAddr[31:28] == 4'hF);
    assign idx     = dmAddr[AW+1:2];
    assign reg_sel = dmAddr[3:2];
    assign off     = dmAddr[1:0];
    assign gpioOut = gpio_q;

`ifdef SR_DMEM_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (is_half && dmAddr[0]) || (is_word && (dmAddr[1:0] != 2'b00));
    assign store_en   = dmWe && !misaligned;
`else
    assign store_en   = dmWe;
`endif

    // Byte enables and lane-replicated write data for the selected access size
    always_comb begin
        be    = 4'b1111;
        wdata = dmDataW;
        if (is_byte) begin
            be    = 4'b0001 << off;
            wdata = {4{dmDataW[7:0]}};
        end else if (is_half) begin
            be    = dmAddr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{dmDataW[15:0]}};
        end
    end

    // RAM store: lane-masked, never reset; stores during reset are dropped
    always_ff @(posedge clk) begin
        if (rst_n && store_en && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Free-running cycle counter; a word store overrides the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= 32'd0;
        end else if (store_en && is_mmio && is_word && reg_sel == 2'd0) begin
            cycle_q <= dmDataW;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // GPIO output register, word stores only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q <= 32'd0;
        end else if (store_en && is_mmio && is_word && reg_sel == 2'd1) begin
            gpio_q <= dmDataW;
        end
    end

`ifdef SR_DMEM_MISALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalignErr <= 1'b0;
        end else if (misaligned) begin
            misalignErr <= 1'b1;
        end
    end
`endif

    // Raw word read from RAM or the MMIO register file
    always_comb begin
        rword = mem[idx];
        if (is_mmio) begin
            case (reg_sel)
                2'd0:    rword = cycle_q;
                2'd1:    rword = gpio_q;
                default: rword = 32'd0;
            endcase
        end
    end

    // Lane extraction and sign/zero extension
    always_comb begin
        case (off)
            2'd0:    byte_lane = rword[7:0];
            2'd1:    byte_lane = rword[15:8];
            2'd2:    byte_lane = rword[23:16];
            default: byte_lane = rword[31:24];
        endcase
        half_lane = dmAddr[1] ? rword[31:16] : rword[15:0];
        dmDataR   = rword;
        if (is_byte) begin
            dmDataR = {{24{dmSign && byte_lane[7]}}, byte_lane};
        end else if (is_half) begin
            dmDataR = {{16{dmSign && half_lane[15]}}, half_lane};
        end
    end

endmodule

// File: tb/tb_sr_dmem.sv
// tb/tb_sr_dmem.sv - directed plus random self-checking bench for sr_dmem
module tb_sr_dmem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dmAddr = 32'hF000_0000;
    logic [31:0] dmDataW = 32'd0;
    logic        dmWe = 1'b0;
    logic        op_byte = 1'b0;
    logic        op_half = 1'b0;
    logic        op_word = 1'b1;
    logic        dmSign = 1'b0;
    logic [31:0] dmDataR;
    logic [31:0] gpioOut;
`ifdef SR_DMEM_MISALIGN_CHECK_EN
    logic        misalignErr;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [64];
    logic [31:0] m_cycle = 32'd0;
    logic [31:0] m_gpio = 32'd0;
    logic        m_err = 1'b0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    sr_dmem #(.DEPTH_WORDS(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dmAddr(dmAddr),
        .dmDataW(dmDataW),
        .dmWe(dmWe),
        .op_byte(op_byte),
        .op_half(op_half),
        .op_word(op_word),
        .dmSign(dmSign),
        .dmDataR(dmDataR),
        .gpioOut(gpioOut)
`ifdef SR_DMEM_MISALIGN_CHECK_EN
        ,
        .misalignErr(misalignErr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    function automatic int word_index(input logic [31:0] addr);
        return int'((addr / 4) % 64);
    endfunction

    function automatic bit is_mis(input logic [31:0] addr, input int sz);
        return (sz == 1 && (addr % 2) != 0) || (sz == 2 && (addr % 4) != 0);
    endfunction

    // Expected load value from the architectural state
    function automatic logic [31:0] model_load(input logic [31:0] addr, input int sz, input bit sign);
        logic [31:0] w;
        logic [31:0] v;
        int          r;
        r = int'((addr / 4) % 4);
        if (addr >= 32'hF000_0000) w = (r == 0) ? m_cycle : (r == 1) ? m_gpio : 32'd0;
        else                       w = m_mem[word_index(addr)];
        if (sz == 0) begin
            v = (w >> (8 * (addr % 4))) % 256;
            if (sign && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (w >> (16 * ((addr / 2) % 2))) % 65536;
            if (sign && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Applies a store to the model; returns 1 when CYCLE was loaded
    function automatic bit model_store(input logic [31:0] addr, input logic [31:0] data, input int sz);
        int i;
        int o;
        int r;
        if (addr >= 32'hF000_0000) begin
            r = int'((addr / 4) % 4);
            if (sz == 2 && r == 0) begin
                m_cycle = data;
                return 1'b1;
            end
            if (sz == 2 && r == 1) m_gpio = data;
            return 1'b0;
        end
        i = word_index(addr);
        if (sz == 0) begin
            o = int'(addr % 4);
            m_mem[i][8*o +: 8] = data[7:0];
        end else if (sz == 1) begin
            o = int'((addr / 2) % 2);
            m_mem[i][16*o +: 16] = data[15:0];
        end else begin
            m_mem[i] = data;
        end
        return 1'b0;
    endfunction

    // One core cycle: drive at posedge+1, sample load mid-cycle, update model at the edge
    task automatic access(input logic [31:0] addr, input logic [31:0] data, input bit we,
                          input int sz, input bit sign, input bit chk, input string tag);
        bit loaded;
        bit mis;
        dmAddr  = addr;
        dmDataW = data;
        dmWe    = we;
        dmSign  = sign;
        op_byte = (sz == 0);
        op_half = (sz == 1) ? 1'b1 : (sz == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        op_word = (sz == 1 || sz == 2) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1));
        #4;
        last_rd = dmDataR;
        if (chk) check(tag, dmDataR, model_load(addr, sz, sign));
        @(posedge clk);
        loaded = 1'b0;
        mis = 1'b0;
`ifdef SR_DMEM_MISALIGN_CHECK_EN
        mis = is_mis(addr, sz);
        if (mis) m_err = 1'b1;
`endif
        if (we && !mis) loaded = model_store(addr, data, sz);
        if (!loaded) m_cycle = m_cycle + 32'd1;
        #1;
        check({tag, "_gpio"}, gpioOut, m_gpio);
`ifdef SR_DMEM_MISALIGN_CHECK_EN
        check({tag, "_merr"}, {31'd0, misalignErr}, {31'd0, m_err});
`endif
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] c0;

        // Reset held across edges: everything cleared
        repeat (3) @(posedge clk);
        #4;
        check("rst_gpio", gpioOut, 32'd0);
        check("rst_cycle", dmDataR, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // CYCLE counts from the first edge after release
        for (int i = 0; i <= 10; i++) access(32'hF000_0000, 32'd0, 1'b0, 2, 1'b0, 1'b1, "cycle_run");
        check("cycle_10", last_rd, 32'd10);

        // Bring RAM to a known state
        for (int i = 0; i < 64; i++) access(i * 4, $urandom, 1'b1, 2, 1'b0, 1'b0, "init");

        // Word store then sign-extended byte loads
        access(32'h10, 32'h8081_7F01, 1'b1, 2, 1'b0, 1'b0, "st10");
        access(32'h10, 32'd0, 1'b0, 0, 1'b1, 1'b1, "lb10");
        check("lb10_k", last_rd, 32'h0000_0001);
        access(32'h11, 32'd0, 1'b0, 0, 1'b1, 1'b1, "lb11");
        check("lb11_k", last_rd, 32'h0000_007F);
        access(32'h12, 32'd0, 1'b0, 0, 1'b1, 1'b1, "lb12");
        check("lb12_k", last_rd, 32'hFFFF_FF81);
        access(32'h13, 32'd0, 1'b0, 0, 1'b1, 1'b1, "lb13");
        check("lb13_k", last_rd, 32'hFFFF_FF80);

        // Byte-lane and half stores with junk in the upper data bits
        access(32'h20, 32'd0, 1'b1, 2, 1'b0, 1'b0, "st20");
        access(32'h22, 32'hFFFF_FFAB, 1'b1, 0, 1'b0, 1'b0, "sb22");
        access(32'h20, 32'h5555_1234, 1'b1, 1, 1'b0, 1'b0, "sh20");
        access(32'h20, 32'd0, 1'b0, 2, 1'b0, 1'b1, "lw20");
        check("lw20_k", last_rd, 32'h00AB_1234);
        access(32'h22, 32'd0, 1'b0, 1, 1'b1, 1'b1, "lh22");
        check("lh22_k", last_rd, 32'h0000_00AB);

        // Same-cycle read returns old data, next cycle new data, RAM aliases
        access(32'h40, 32'h9, 1'b1, 2, 1'b0, 1'b0, "st40a");
        access(32'h40, 32'h5, 1'b1, 2, 1'b0, 1'b1, "st40b");
        check("rdw_old", last_rd, 32'h9);
        access(32'h40, 32'd0, 1'b0, 2, 1'b0, 1'b1, "ld40");
        check("rdw_new", last_rd, 32'h5);
        access(32'h140, 32'd0, 1'b0, 2, 1'b0, 1'b1, "ld140");
        check("alias", last_rd, 32'h5);

        // CYCLE load and wrap
        access(32'hF000_0000, 32'hFFFF_FFFF, 1'b1, 2, 1'b0, 1'b0, "cyc_ld");
        access(32'hF000_0000, 32'd0, 1'b0, 2, 1'b0, 1'b1, "cyc_v");
        check("cyc_v_k", last_rd, 32'hFFFF_FFFF);
        access(32'hF000_0000, 32'd0, 1'b0, 2, 1'b0, 1'b1, "cyc_w");
        check("cyc_w_k", last_rd, 32'h0);
        access(32'hF000_0000, 32'd0, 1'b0, 2, 1'b0, 1'b1, "cyc_1");
        check("cyc_1_k", last_rd, 32'h1);

        // Byte store to CYCLE is ignored: it just keeps counting
        access(32'hF000_0000, 32'h55, 1'b1, 0, 1'b0, 1'b1, "cyc_sb");
        c0 = last_rd;
        access(32'hF000_0000, 32'd0, 1'b0, 2, 1'b0, 1'b1, "cyc_sb_n");
        check("cyc_sb_k", last_rd, c0 + 32'd1);

        // GPIO, reserved registers, sub-word MMIO stores
        access(32'hF000_0004, 32'hDEAD_BEEF, 1'b1, 2, 1'b0, 1'b0, "gpio_st");
        check("gpio_k", gpioOut, 32'hDEAD_BEEF);
        access(32'hF123_4564, 32'h1234_5678, 1'b1, 1, 1'b0, 1'b1, "gpio_sh");
        check("gpio_sh_k", gpioOut, 32'hDEAD_BEEF);
        access(32'hF000_0008, 32'h7777_7777, 1'b1, 2, 1'b0, 1'b0, "rsv_st");
        access(32'hF000_0008, 32'd0, 1'b0, 2, 1'b0, 1'b1, "rsv_ld");
        check("rsv_k", last_rd, 32'd0);

        // Asynchronous mid-cycle reset, store during reset is discarded
        dmAddr = 32'hF000_0000;
        dmWe   = 1'b0;
        op_byte = 1'b0;
        op_half = 1'b0;
        op_word = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_gpio", gpioOut, 32'd0);
        check("arst_cycle", dmDataR, 32'd0);
        m_gpio  = 32'd0;
        m_cycle = 32'd0;
        m_err   = 1'b0;
        dmAddr  = 32'h10;
        dmDataW = 32'h1234_5678;
        dmWe    = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        access(32'hF000_0000, 32'd0, 1'b0, 2, 1'b0, 1'b1, "rel0");
        access(32'hF000_0000, 32'd0, 1'b0, 2, 1'b0, 1'b1, "rel1");
        check("rel1_k", last_rd, 32'd1);
        access(32'h10, 32'd0, 1'b0, 2, 1'b0, 1'b1, "rst_st_drop");

`ifdef SR_DMEM_MISALIGN_CHECK_EN
        // Misaligned word store is suppressed and flags sticky error
        access(32'h30, 32'hA5A5_0000, 1'b1, 2, 1'b0, 1'b0, "st30");
        access(32'h31, 32'h1111_1111, 1'b1, 2, 1'b0, 1'b0, "mis31");
        check("mis_flag", {31'd0, misalignErr}, 32'd1);
        access(32'h30, 32'd0, 1'b0, 2, 1'b0, 1'b1, "ld30");
        check("mis_keep", last_rd, 32'hA5A5_0000);
        access(32'h34, 32'd0, 1'b0, 2, 1'b0, 1'b1, "ld34");
        check("mis_sticky", {31'd0, misalignErr}, 32'd1);
`endif

        // Randomized accesses against the reference model
        for (int n = 0; n < 500; n++) begin
            r = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = {4'hF, r[27:0]};
            end else begin
                a = r;
                if (a[31:28] == 4'hF) a[31:28] = 4'h0;
            end
            access(a, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), 1'b1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got %0d exp 0", checks);
        $fatal(1, "timeout");
    end
endmodule
